// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported memory between an instruction-fetch requester and a
// data requester. Data requests take priority over fetches. Loads and fetches
// are pipelined, so a grant can be issued every cycle while the response to the
// previous grant is returned. Byte and half-word stores are done as a
// read-modify-write of the containing word. Misaligned or illegal data
// requests are accepted but never reach memory and are answered with d_err_o.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   if_req_i/if_addr_i        fetch request and byte address
//   if_gnt_o                  fetch accepted this cycle
//   if_rvalid_o/if_rdata_o    fetch data, one cycle after the grant
//   d_req_i/d_we_i/d_size_i   data request, store, size (00 B, 01 H, 10 W, 11 illegal)
//   d_unsigned_i              zero-extend a byte/half load
//   d_addr_i/d_wdata_i        data byte address, right-aligned store data
//   d_gnt_o                   data request accepted this cycle
//   d_rvalid_o/d_rdata_o      load data, one cycle after the grant
//   d_done_o                  store complete
//   d_err_o                   misaligned or illegal request
//   memread_o/memwrite_o      memory strobes (never both high)
//   memaddr_o                 word-aligned memory address
//   memwdata_o                memory write data
//   memrdata_i                memory read data, valid the cycle after memread_o
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [WIDTH-1:0]      if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [1:0]            d_size_i,
  input  logic                  d_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [WIDTH-1:0]      d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic                  d_done_o,
  output logic                  d_err_o,
  output logic [WIDTH-1:0]      d_rdata_o,
  output logic                  memread_o,
  output logic                  memwrite_o,
  output logic [ADDR_WIDTH-1:0] memaddr_o,
  output logic [WIDTH-1:0]      memwdata_o,
  input  logic [WIDTH-1:0]      memrdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RMW_RD = 2'b01,
    ST_RMW_WR = 2'b10
  } state_t;

  // Who the response in the next cycle belongs to.
  typedef enum logic [2:0] {
    OWN_NONE   = 3'd0,
    OWN_IF     = 3'd1,
    OWN_DLOAD  = 3'd2,
    OWN_DSTORE = 3'd3,
    OWN_DERR   = 3'd4
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Registered state
  state_t                  state_r;
  owner_t                  owner_r;
  logic [1:0]              off_r;
  logic [1:0]              size_r;
  logic                    uns_r;
  logic [ADDR_WIDTH-1:0]   st_addr_r;
  logic [1:0]              st_off_r;
  logic [1:0]              st_size_r;
  logic [WIDTH-1:0]        st_wdata_r;
  logic [WIDTH-1:0]        merged_r;

  // Next-state / combinational outputs
  state_t                  state_s;
  owner_t                  owner_s;
  logic [1:0]              off_s;
  logic [1:0]              size_s;
  logic                    uns_s;
  logic [ADDR_WIDTH-1:0]   st_addr_s;
  logic [1:0]              st_off_s;
  logic [1:0]              st_size_s;
  logic [WIDTH-1:0]        st_wdata_s;
  logic [WIDTH-1:0]        merged_s;
  logic                    if_gnt_s;
  logic                    d_gnt_s;
  logic                    memread_s;
  logic                    memwrite_s;
  logic [ADDR_WIDTH-1:0]   memaddr_s;
  logic [WIDTH-1:0]        memwdata_s;

  // Fetch addresses are always word aligned by the memory port.
  logic                    unused_if_low_s;
  assign unused_if_low_s = ^if_addr_i[1:0];

  // Word-aligned version of a byte address.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  // True when the access cannot be performed as a single aligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane from a memory word and sign/zero extend it.
  function automatic logic [WIDTH-1:0] load_extract(input logic [WIDTH-1:0] word,
                                                    input logic [1:0]       off,
                                                    input logic [1:0]       size,
                                                    input logic             uns);
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: begin
        if (uns) begin
          res = {{(WIDTH-8){1'b0}}, sh[7:0]};
        end else begin
          res = {{(WIDTH-8){sh[7]}}, sh[7:0]};
        end
      end
      SZ_HALF: begin
        if (uns) begin
          res = {{(WIDTH-16){1'b0}}, sh[15:0]};
        end else begin
          res = {{(WIDTH-16){sh[15]}}, sh[15:0]};
        end
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the byte or half-word lane selected by off with the low store bits.
  function automatic logic [WIDTH-1:0] store_merge(input logic [WIDTH-1:0] old_word,
                                                   input logic [WIDTH-1:0] wdata,
                                                   input logic [1:0]       off,
                                                   input logic [1:0]       size);
    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] ins;
    if (size == SZ_HALF) begin
      lane_mask = {{(WIDTH-16){1'b0}}, 16'hFFFF};
    end else begin
      lane_mask = {{(WIDTH-8){1'b0}}, 8'hFF};
    end
    lane_mask = lane_mask << {off, 3'b000};
    ins       = wdata << {off, 3'b000};
    return (old_word & ~lane_mask) | (ins & lane_mask);
  endfunction

  // Arbitration, memory strobes and next-state selection.
  always_comb begin
    state_s    = state_r;
    owner_s    = OWN_NONE;
    off_s      = off_r;
    size_s     = size_r;
    uns_s      = uns_r;
    st_addr_s  = st_addr_r;
    st_off_s   = st_off_r;
    st_size_s  = st_size_r;
    st_wdata_s = st_wdata_r;
    merged_s   = merged_r;
    if_gnt_s   = 1'b0;
    d_gnt_s    = 1'b0;
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    memaddr_s  = {ADDR_WIDTH{1'b0}};
    memwdata_s = {WIDTH{1'b0}};
    // While reset is held every combinational output stays low even if the
    // requesters are already asserting.
    if (rst) begin
      case (state_r)
        ST_IDLE: begin
          if (d_req_i) begin
            d_gnt_s = 1'b1;
            if (is_misaligned(d_size_i, d_addr_i[1:0])) begin
              owner_s = OWN_DERR;
            end else if (!d_we_i) begin
              memread_s = 1'b1;
              memaddr_s = word_align(d_addr_i);
              owner_s   = OWN_DLOAD;
              off_s     = d_addr_i[1:0];
              size_s    = d_size_i;
              uns_s     = d_unsigned_i;
            end else if (d_size_i == SZ_WORD) begin
              memwrite_s = 1'b1;
              memaddr_s  = word_align(d_addr_i);
              memwdata_s = d_wdata_i;
              owner_s    = OWN_DSTORE;
            end else begin
              // Sub-word store: read the old word first.
              memread_s  = 1'b1;
              memaddr_s  = word_align(d_addr_i);
              st_addr_s  = word_align(d_addr_i);
              st_off_s   = d_addr_i[1:0];
              st_size_s  = d_size_i;
              st_wdata_s = d_wdata_i;
              state_s    = ST_RMW_RD;
            end
          end else if (if_req_i) begin
            if_gnt_s  = 1'b1;
            memread_s = 1'b1;
            memaddr_s = word_align(if_addr_i);
            owner_s   = OWN_IF;
          end else begin
            owner_s = OWN_NONE;
          end
        end
        ST_RMW_RD: begin
          merged_s = store_merge(memrdata_i, st_wdata_r, st_off_r, st_size_r);
          state_s  = ST_RMW_WR;
        end
        ST_RMW_WR: begin
          memwrite_s = 1'b1;
          memaddr_s  = st_addr_r;
          memwdata_s = merged_r;
          owner_s    = OWN_DSTORE;
          state_s    = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = ST_IDLE;
      owner_s = OWN_NONE;
    end
  end

  // State, response owner and store-buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      owner_r    <= OWN_NONE;
      off_r      <= 2'b00;
      size_r     <= 2'b00;
      uns_r      <= 1'b0;
      st_addr_r  <= {ADDR_WIDTH{1'b0}};
      st_off_r   <= 2'b00;
      st_size_r  <= 2'b00;
      st_wdata_r <= {WIDTH{1'b0}};
      merged_r   <= {WIDTH{1'b0}};
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      off_r      <= off_s;
      size_r     <= size_s;
      uns_r      <= uns_s;
      st_addr_r  <= st_addr_s;
      st_off_r   <= st_off_s;
      st_size_r  <= st_size_s;
      st_wdata_r <= st_wdata_s;
      merged_r   <= merged_s;
    end
  end

  assign if_gnt_o   = if_gnt_s;
  assign d_gnt_o    = d_gnt_s;
  assign memread_o  = memread_s;
  assign memwrite_o = memwrite_s;
  assign memaddr_o  = memaddr_s;
  assign memwdata_o = memwdata_s;

  // Responses are decoded from the registered owner tag, so each is a
  // single-cycle pulse that can overlap with the next grant.
  assign if_rvalid_o = (owner_r == OWN_IF);
  assign d_rvalid_o  = (owner_r == OWN_DLOAD);
  assign d_done_o    = (owner_r == OWN_DSTORE);
  assign d_err_o     = (owner_r == OWN_DERR);
  assign if_rdata_o  = if_rvalid_o ? memrdata_i : {WIDTH{1'b0}};
  assign d_rdata_o   = d_rvalid_o ? load_extract(memrdata_i, off_r, size_r, uns_r)
                                  : {WIDTH{1'b0}};

endmodule
